// File: rtl/core_pkg.sv
// Shared core definitions: operand width, B-operand select codes and forwarding selects.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic B_SEL_REG = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu_input_mux_b_fwd_resolve.sv
// Resolves the register-side B operand from the register file or a forwarding source.
module fwd_resolve
  import core_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [1:0]       fwd_sel,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] fwd_mem_data,
  input  logic [WIDTH-1:0] fwd_wb_data,
  output logic [WIDTH-1:0] reg_operand
);

  always_comb begin
    reg_operand = data2;
    // 2'b11 is unused and falls back to the register file value
    case (fwd_sel_e'(fwd_sel))
      FWD_MEM: reg_operand = fwd_mem_data;
      FWD_WB:  reg_operand = fwd_wb_data;
      default: reg_operand = data2;
    endcase
  end

endmodule

// File: rtl/alu_input_mux_b.sv
// Execute-stage ALU B operand mux with registered copy and immediate-select counter.
// Optional operand forwarding is enabled by defining ALU_B_MUX_FWD_EN.
module alu_input_mux_b
  import core_pkg::*;
#(
  parameter int WIDTH     = XLEN,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data2,
  input  logic [WIDTH-1:0]     immGenData,
  input  logic                 B_select,
`ifdef ALU_B_MUX_FWD_EN
  input  logic [1:0]           fwd_sel,
  input  logic [WIDTH-1:0]     fwd_mem_data,
  input  logic [WIDTH-1:0]     fwd_wb_data,
`endif
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 sel_q,
  output logic [CNT_WIDTH-1:0] imm_cnt
);

  logic [WIDTH-1:0]     reg_operand;
  logic [WIDTH-1:0]     out_q_reg;
  logic                 sel_q_reg;
  logic [CNT_WIDTH-1:0] imm_cnt_reg;

`ifdef ALU_B_MUX_FWD_EN
  fwd_resolve #(
    .WIDTH(WIDTH)
  ) u_fwd_resolve (
    .fwd_sel      (fwd_sel),
    .data2        (data2),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_data  (fwd_wb_data),
    .reg_operand  (reg_operand)
  );
`else
  assign reg_operand = data2;
`endif

  // The immediate path is never forwarded
  assign out = (B_select == B_SEL_IMM) ? immGenData : reg_operand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_reg   <= '0;
      sel_q_reg   <= 1'b0;
      imm_cnt_reg <= '0;
    end else begin
      out_q_reg <= out;
      sel_q_reg <= B_select;
      // Debug counter saturates rather than wrapping
      if (B_select == B_SEL_IMM && imm_cnt_reg != {CNT_WIDTH{1'b1}})
        imm_cnt_reg <= imm_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign out_q   = out_q_reg;
  assign sel_q   = sel_q_reg;
  assign imm_cnt = imm_cnt_reg;

endmodule

// File: tb/tb_alu_input_mux_b.sv
// Directed-vector bench for alu_input_mux_b; forwarding vectors run when ALU_B_MUX_FWD_EN is defined.
module tb_alu_input_mux_b;

  logic        clk;
  logic        rst;
  logic [31:0] data2;
  logic [31:0] imm_gen_data;
  logic        b_select;
  logic        b_select4;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        sel_q;
  logic [31:0] imm_cnt;
  logic [31:0] out4;
  logic [31:0] out_q4;
  logic        sel_q4;
  logic [3:0]  imm_cnt4;
`ifdef ALU_B_MUX_FWD_EN
  logic [1:0]  fwd_sel;
  logic [31:0] fwd_mem_data;
  logic [31:0] fwd_wb_data;
`endif

  int checks;
  int failures;

  alu_input_mux_b dut (
    .clk        (clk),
    .rst        (rst),
    .data2      (data2),
    .immGenData (imm_gen_data),
    .B_select   (b_select),
`ifdef ALU_B_MUX_FWD_EN
    .fwd_sel      (fwd_sel),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_data  (fwd_wb_data),
`endif
    .out        (out),
    .out_q      (out_q),
    .sel_q      (sel_q),
    .imm_cnt    (imm_cnt)
  );

  // Narrow-counter instance for the saturation vectors
  alu_input_mux_b #(
    .WIDTH     (32),
    .CNT_WIDTH (4)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .data2      (data2),
    .immGenData (imm_gen_data),
    .B_select   (b_select4),
`ifdef ALU_B_MUX_FWD_EN
    .fwd_sel      (2'b00),
    .fwd_mem_data (32'h0),
    .fwd_wb_data  (32'h0),
`endif
    .out        (out4),
    .out_q      (out_q4),
    .sel_q      (sel_q4),
    .imm_cnt    (imm_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s observed=0x%08h", tag, obs);
    end
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    data2 = 32'h0;
    imm_gen_data = 32'h0;
    b_select = 1'b0;
    b_select4 = 1'b0;
`ifdef ALU_B_MUX_FWD_EN
    fwd_sel = 2'b00;
    fwd_mem_data = 32'h0;
    fwd_wb_data = 32'h0;
`endif

    #2;
    check("rst_out_q", out_q, 32'h0);
    check("rst_sel_q", {31'h0, sel_q}, 32'h0);
    check("rst_imm_cnt", imm_cnt, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Combinational select, no clock edge between drive and sample
    imm_gen_data = 32'h00510193; data2 = 32'h00200113; b_select = 1'b1;
    #1 check("comb_imm", out, 32'h00510193);
    imm_gen_data = 32'h00100093; data2 = 32'h00008067; b_select = 1'b0;
    #1 check("comb_reg", out, 32'h00008067);

    @(negedge clk);
    b_select = 1'b1;
    repeat (3) edge_then_settle();
    check("cnt_after_3", imm_cnt, 32'd3);
    check("out_q_imm", out_q, 32'h00100093);
    check("sel_q_one", {31'h0, sel_q}, 32'h1);
    b_select = 1'b0;
    repeat (2) edge_then_settle();
    check("cnt_hold", imm_cnt, 32'd3);
    check("out_q_reg", out_q, 32'h00008067);
    check("sel_q_zero", {31'h0, sel_q}, 32'h0);

    data2 = 32'h11111111;
    edge_then_settle();
    check("out_q_first", out_q, 32'h11111111);
    data2 = 32'h22222222;
    #1;
    check("out_immediate", out, 32'h22222222);
    check("out_q_stale", out_q, 32'h11111111);
    edge_then_settle();
    check("out_q_next", out_q, 32'h22222222);

    // Bring counter to 5, then reset between edges
    b_select = 1'b1;
    repeat (2) edge_then_settle();
    check("cnt_five", imm_cnt, 32'd5);
    check("out_q_nonzero", out_q, 32'h00100093);
    rst = 1'b1;
    #1;
    check("async_out_q", out_q, 32'h0);
    check("async_sel_q", {31'h0, sel_q}, 32'h0);
    check("async_cnt", imm_cnt, 32'h0);
    check("rst_out_tracks", out, 32'h00100093);
    imm_gen_data = 32'hA5A5F00F;
    #1 check("rst_out_follow", out, 32'hA5A5F00F);
    edge_then_settle();
    check("rst_hold_cnt", imm_cnt, 32'h0);
    rst = 1'b0;
    edge_then_settle();
    check("resume_cnt", imm_cnt, 32'd1);
    check("resume_out_q", out_q, 32'hA5A5F00F);
    b_select = 1'b0;

    // Saturation on the 4-bit counter
    b_select4 = 1'b1;
    repeat (14) edge_then_settle();
    check("sat_cnt_14", {28'h0, imm_cnt4}, 32'hE);
    repeat (6) edge_then_settle();
    check("sat_cnt_hold", {28'h0, imm_cnt4}, 32'hF);
    b_select4 = 1'b0;

`ifdef ALU_B_MUX_FWD_EN
    data2 = 32'h12345678;
    imm_gen_data = 32'h00000FFF;
    fwd_sel = 2'b01; fwd_mem_data = 32'hDEADBEEF; fwd_wb_data = 32'hCAFEF00D;
    #1 check("fwd_mem", out, 32'hDEADBEEF);
    fwd_sel = 2'b10;
    #1 check("fwd_wb", out, 32'hCAFEF00D);
    fwd_sel = 2'b11;
    #1 check("fwd_11", out, 32'h12345678);
    fwd_sel = 2'b01; b_select = 1'b1;
    #1 check("fwd_imm", out, 32'h00000FFF);
    b_select = 1'b0; fwd_sel = 2'b00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
